// File: rtl/jam_cost_table.sv
// rtl/jam_cost_table.sv - JAM cost table with load stream, 1-cycle reads and row-minimum lower bound
//
// Purpose:
//    Holds the N x N (8 x 8) cost table used by the JAM job-assignment engine.
//    The table arrives as a row-major valid/ready word stream. Once the table is
//    complete, the block serves W/J read requests with one cycle of latency.
//    It also keeps the minimum cost of each worker row and the sum of those
//    minimums, which JAM can use as a pruning bound.
//
// Ports:
//    CLK          in   clock, rising edge
//    RST          in   synchronous active-high reset
//    load_start   in   pulse: drop the current table and start a new 64-word load
//    in_valid     in   load word present on in_data
//    in_ready     out  a load word is accepted this cycle (state LOAD)
//    in_data      in   cost word, row-major (index = worker*8 + job)
//    W, J         in   worker / job index of the read request
//    Cost         out  registered mem[{W,J}] from the previous edge (0 when not ready)
//    RowMin       out  registered minimum of row W from the previous edge (0 when not ready)
//    LbSum        out  sum of the row minimums, final while table_ready = 1
//    table_ready  out  table fully loaded and readable (state READY)

module jam_cost_table #(
   parameter int DW = 7,
   parameter int N  = 8,
   parameter int SW = 10
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          load_start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic [2:0]    W,
   input  logic [2:0]    J,
   output logic [DW-1:0] Cost,
   output logic [DW-1:0] RowMin,
   output logic [SW-1:0] LbSum,
   output logic          table_ready
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_READY = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next_state;

   // Table storage and per-row minimums; contents are don't-care after reset.
   logic [DW-1:0] r_mem     [0:N*N-1];
   logic [DW-1:0] r_row_min [0:N-1];

   logic [5:0]    r_cnt;
   logic [DW-1:0] r_run_min;
   logic [SW-1:0] r_lb_sum;
   logic [DW-1:0] r_cost;
   logic [DW-1:0] r_row_min_out;

   logic          w_in_ready;
   logic          w_table_ready;
   logic          w_accept;
   logic          w_row_first;
   logic          w_row_last;
   logic [DW-1:0] w_new_min;

   // load_start has priority: a word offered alongside it is dropped.
   assign w_accept    = (r_state == S_LOAD) && in_valid && !load_start;
   assign w_row_first = (r_cnt[2:0] == 3'd0);
   assign w_row_last  = (r_cnt[2:0] == 3'd7);

   // Minimum of the row so far including the word being accepted. The first
   // word of a row restarts the minimum rather than comparing against the
   // previous row's leftover value.
   always_comb begin
      w_new_min = in_data;
      if (!w_row_first && (r_run_min < in_data)) begin
         w_new_min = r_run_min;
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = r_state;
      if (load_start) begin
         w_next_state = S_LOAD;
      end else begin
         case (r_state)
            S_IDLE:  w_next_state = S_IDLE;
            S_LOAD: begin
               if (w_accept && (r_cnt == 6'd63)) begin
                  w_next_state = S_READY;
               end
            end
            S_READY: w_next_state = S_READY;
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_in_ready    = 1'b0;
      w_table_ready = 1'b0;
      case (r_state)
         S_LOAD:  w_in_ready    = 1'b1;
         S_READY: w_table_ready = 1'b1;
         default: begin
            w_in_ready    = 1'b0;
            w_table_ready = 1'b0;
         end
      endcase
   end

   // ---------------- storage writes (no reset) ----------------
   always_ff @(posedge CLK) begin
      if (w_accept) begin
         r_mem[r_cnt] <= in_data;
         if (w_row_last) begin
            r_row_min[r_cnt[5:3]] <= w_new_min;
         end
      end
   end

   // ---------------- load counter, running minimum, bound sum ----------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt     <= 6'd0;
         r_run_min <= '0;
         r_lb_sum  <= '0;
      end else if (load_start) begin
         r_cnt     <= 6'd0;
         r_run_min <= '0;
         r_lb_sum  <= '0;
      end else if (w_accept) begin
         r_cnt     <= r_cnt + 6'd1;
         r_run_min <= w_new_min;
         if (w_row_last) begin
            r_lb_sum <= r_lb_sum + {{(SW-DW){1'b0}}, w_new_min};
         end
      end
   end

   // ---------------- read path ----------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cost        <= '0;
         r_row_min_out <= '0;
      end else if (w_table_ready) begin
         r_cost        <= r_mem[{W, J}];
         r_row_min_out <= r_row_min[W];
      end else begin
         r_cost        <= '0;
         r_row_min_out <= '0;
      end
   end

   assign in_ready    = w_in_ready;
   assign table_ready = w_table_ready;
   assign Cost        = r_cost;
   assign RowMin      = r_row_min_out;
   assign LbSum       = r_lb_sum;

endmodule

// File: tb/tb_jam_cost_table.sv
// tb/tb_jam_cost_table.sv - directed self-checking bench for jam_cost_table

module tb_jam_cost_table;

   logic       CLK = 1'b0;
   logic       RST;
   logic       load_start;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] in_data;
   logic [2:0] W;
   logic [2:0] J;
   logic [6:0] Cost;
   logic [6:0] RowMin;
   logic [9:0] LbSum;
   logic       table_ready;

   int checks   = 0;
   int failures = 0;

   logic [6:0] tbl [0:63];

   jam_cost_table #(.DW(7), .N(8), .SW(10)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .load_start  (load_start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .W           (W),
      .J           (J),
      .Cost        (Cost),
      .RowMin      (RowMin),
      .LbSum       (LbSum),
      .table_ready (table_ready)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] row_min_model(input int w);
      logic [6:0] m;
      m = tbl[w*8];
      for (int j = 1; j < 8; j++) begin
         if (tbl[w*8+j] < m) m = tbl[w*8+j];
      end
      return m;
   endfunction

   // Pulses load_start, then streams tbl. With toggle set, in_valid alternates
   // 1/0 starting high. When abort_at >= 0, after that many accepted words a
   // word (99) is offered together with load_start, and the load restarts.
   // n counts edges from the load_start edge to the first table_ready sample.
   task automatic do_load(input string tag, input int toggle, input int abort_at, output int n);
      int idx;
      int ph;
      int abort;
      int bad_ready;
      logic acc;
      abort     = abort_at;
      bad_ready = 0;
      load_start = 1'b1;
      in_valid   = 1'b0;
      tick();
      load_start = 1'b0;
      n   = 1;
      idx = 0;
      ph  = 0;
      while (!table_ready && n < 400) begin
         if (idx == abort) begin
            load_start = 1'b1;
            in_valid   = 1'b1;
            in_data    = 7'd99;
            tick();
            load_start = 1'b0;
            in_valid   = 1'b0;
            n     = 1;
            idx   = 0;
            ph    = 0;
            abort = -1;
         end else begin
            in_valid = (toggle != 0) ? (ph == 0) : 1'b1;
            ph       = 1 - ph;
            in_data  = tbl[idx[5:0]];
            if (in_ready !== 1'b1) bad_ready++;
            acc = in_valid && in_ready;
            tick();
            n++;
            if (acc) idx++;
         end
      end
      in_valid = 1'b0;
      chk({tag, "_in_ready_during_load"}, bad_ready, 0);
      chk({tag, "_words_accepted"}, idx, 64);
   endtask

   // Drives every address on consecutive cycles; each result is checked right
   // after the edge that registered it.
   task automatic sweep(input string tag);
      logic [5:0] a6;
      for (int a = 0; a < 64; a++) begin
         a6 = a[5:0];
         W  = a6[5:3];
         J  = a6[2:0];
         tick();
         chk({tag, "_cost"}, Cost, tbl[a]);
         chk({tag, "_rowmin"}, RowMin, row_min_model(a / 8));
      end
   endtask

   initial begin
      int n;
      RST        = 1'b1;
      load_start = 1'b0;
      in_valid   = 1'b0;
      in_data    = 7'd0;
      W          = 3'd0;
      J          = 3'd0;
      tick();
      tick();
      RST = 1'b0;

      // Reset state
      chk("rst_cost", Cost, 0);
      chk("rst_rowmin", RowMin, 0);
      chk("rst_lbsum", LbSum, 0);
      chk("rst_table_ready", table_ready, 0);
      chk("rst_in_ready", in_ready, 0);
      in_valid = 1'b1;
      tick();
      tick();
      chk("idle_in_ready", in_ready, 0);
      chk("idle_table_ready", table_ready, 0);
      in_valid = 1'b0;

      // Test 1: cost = w*8+j, in_valid held high
      for (int i = 0; i < 64; i++) tbl[i] = 7'(i);
      do_load("t1", 0, -1, n);
      chk("t1_ready_latency", n, 65);
      chk("t1_in_ready_ready", in_ready, 0);
      W = 3'd3; J = 3'd5;
      tick();
      chk("t1_cost_3_5", Cost, 29);
      chk("t1_rowmin_3", RowMin, 24);
      chk("t1_lbsum", LbSum, 224);
      sweep("t1");

      // Test 2: same table, in_valid toggling
      do_load("t2", 1, -1, n);
      chk("t2_ready_latency", n, 128);
      W = 3'd3; J = 3'd5;
      tick();
      chk("t2_cost_3_5", Cost, 29);
      chk("t2_rowmin_3", RowMin, 24);
      chk("t2_lbsum", LbSum, 224);
      sweep("t2");

      // Test 3: all 127
      for (int i = 0; i < 64; i++) tbl[i] = 7'd127;
      do_load("t3", 0, -1, n);
      chk("t3_lbsum", LbSum, 1016);
      sweep("t3");

      // Test 4: abort at cnt 40 with a word offered, reload all 5
      for (int i = 0; i < 64; i++) tbl[i] = 7'd5;
      do_load("t4", 0, 40, n);
      chk("t4_ready_latency", n, 65);
      chk("t4_lbsum", LbSum, 40);
      sweep("t4");

      // Test 6: repeated minimum in row 0
      for (int i = 0; i < 64; i++) tbl[i] = 7'd100;
      tbl[0] = 7'd9;  tbl[1] = 7'd3;  tbl[2] = 7'd7;  tbl[3] = 7'd3;
      tbl[4] = 7'd50; tbl[5] = 7'd3;  tbl[6] = 7'd60; tbl[7] = 7'd4;
      do_load("t6", 0, -1, n);
      W = 3'd0; J = 3'd6;
      tick();
      chk("t6_rowmin_0", RowMin, 3);
      chk("t6_cost_0_6", Cost, 60);
      W = 3'd1; J = 3'd0;
      tick();
      chk("t6_rowmin_1", RowMin, 100);
      chk("t6_lbsum", LbSum, 703);

      // Test 5: reads during LOAD, then RST mid-load
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("t5_table_ready_drop", table_ready, 0);
      W = 3'd3; J = 3'd5;
      in_valid = 1'b1;
      in_data  = 7'd11;
      for (int i = 0; i < 10; i++) tick();
      chk("t5_load_cost", Cost, 0);
      chk("t5_load_rowmin", RowMin, 0);
      chk("t5_load_table_ready", table_ready, 0);
      chk("t5_load_in_ready", in_ready, 1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("t5_rst_cost", Cost, 0);
      chk("t5_rst_rowmin", RowMin, 0);
      chk("t5_rst_table_ready", table_ready, 0);
      chk("t5_rst_in_ready", in_ready, 0);
      chk("t5_rst_lbsum", LbSum, 0);
      for (int i = 0; i < 70; i++) tick();
      chk("t5_idle_in_ready", in_ready, 0);
      chk("t5_idle_table_ready", table_ready, 0);
      chk("t5_idle_cost", Cost, 0);
      in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Synthesizable cost memory that sits directly upstream of the JAM job-assignment engine, replacing the bench-side cost ROM.
- Accepts a 64-entry 8x8 cost table through a valid/ready load stream.
- Serves JAM's W/J read requests with one-cycle latency.
- Computes each worker's minimum cost and the sum of those minimums (lower bound), which JAM may use to prune.

Parameters:
- DW, 7, cost word width (values 0..127)
- N, 8, workers = jobs per side (table holds N*N words; N fixed to 8 in this revision)
- SW, 10, lower-bound sum width (8*127 = 1016 fits)

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- load_start  input  1  one-cycle pulse: discard the table and begin a new 64-word load
- in_valid  input  1  load word present on in_data
- in_ready  output  1  block accepts a load word this cycle
- in_data  input  DW  cost word, row-major order (index = worker*8 + job)
- W  input  3  worker index of read request
- J  input  3  job index of read request
- Cost  output  DW  registered read data for {W,J} sampled at the previous edge
- RowMin  output  DW  registered minimum of row W sampled at the previous edge
- LbSum  output  SW  sum of the 8 row minimums; valid while table_ready = 1
- table_ready  output  1  table fully loaded and readable

Behaviour:
- FSM states:
  - IDLE: in_ready = 0, table_ready = 0.
  - LOAD: in_ready = 1.
  - READY: in_ready = 0, table_ready = 1.
- Reset: state IDLE; Cost, RowMin, LbSum, table_ready, in_ready, load counter and running minimum all 0. Memory contents are not cleared and are don't-care.
- Transitions:
  - load_start in any state moves to LOAD next cycle and clears the counter, LbSum and running minimum. table_ready drops the cycle after load_start.
  - LOAD -> READY on the edge that accepts the 64th word; table_ready = 1 from the next cycle.
  - READY persists until load_start or RST.
- Accept rule: a word is accepted on an edge where state = LOAD, in_valid = 1 and load_start = 0.
  - Accepted word written to mem[cnt]; cnt increments 0..63.
  - in_valid may drop for any number of cycles; cnt holds.
- Simultaneous load_start and in_valid in LOAD: load_start wins, the word is discarded, cnt returns to 0.
- Row minimum:
  - Running min is reset to the first word of each row (cnt[2:0] = 0) and updated with unsigned compare on the rest of the row.
  - On the word with cnt[2:0] = 7, row_min[cnt[5:3]] is written and LbSum += that row minimum (zero-extended to SW).
  - Ties keep the value; only the value matters, not the position.
- Read path:
  - If table_ready = 1 at edge k: Cost <= mem[{W,J}] and RowMin <= row_min[W], visible after edge k.
  - This gives one-cycle latency matching JAM's expectation: drive W/J, consume Cost next cycle.
  - If table_ready = 0: Cost and RowMin are registered as 0.
- Reads in READY are unlimited and have no handshake; any W/J value every cycle.
- LbSum holds its final value throughout READY; its value during LOAD is a partial sum and is not guaranteed.
- RST asserted mid-load aborts to IDLE; a new load_start is required.
- No arithmetic overflow is possible: max LbSum = 1016 < 1024.

Test Plan:
- Load cost[w][j] = (w*8 + j) % 128 with in_valid held high, starting 1 cycle after load_start.
  - table_ready rises 65 cycles after load_start.
  - Read W=3, J=5 gives Cost = 29 one cycle later.
  - RowMin(W=3) = 24; LbSum = 0+8+16+...+56 = 224.
- Same table with in_valid toggling 1/0 every cycle.
  - table_ready rises about 128 cycles after load_start.
  - Identical Cost/RowMin/LbSum; in_ready stays 1 throughout LOAD.
- All words 127.
  - LbSum = 1016; Cost = 127 for every {W,J} swept over 64 consecutive cycles, each lagging its address by exactly one cycle.
- load_start asserted together with in_valid at cnt = 40, then reload all 64 words = 5.
  - The word presented with load_start is not written.
  - table_ready = 1 only after the full 64-word reload.
  - LbSum = 40; no residue of the first table.
- Reads during LOAD and after RST pulsed mid-load.
  - Cost = 0, RowMin = 0, table_ready = 0, in_ready = 0 after reset.
  - State stays IDLE until load_start.
- Row with repeated minimum {9,3,7,3,50,3,60,4} as worker 0, all other rows 100.
  - RowMin(W=0) = 3; LbSum = 3 + 7*100 = 703.
